// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the 111010 sync-word frame transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_GAP
  } tx_state_t;

  localparam logic [5:0] DEFAULT_SYNC = 6'b111010;

  // One down-counter serves every state, so it must hold the largest reload value.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_111010_frame_tx_piso_shreg.sv
// Parallel-load, MSB-first shift register holding the payload of the frame in flight.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/seq_111010_frame_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, then a forced idle gap.
module seq_111010_frame_tx
  import seq_tx_pkg::*;
#(
  parameter int                SYNC_W     = 6,
  parameter logic [SYNC_W-1:0] SYNC       = DEFAULT_SYNC,
  parameter int                DATA_W     = 8,
  parameter int                GAP_CYCLES = 2,
  parameter logic              IDLE_BIT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done
);

  localparam int CNT_W  = cnt_width(SYNC_W, DATA_W, GAP_CYCLES);
  localparam int SIDX_W = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;

  tx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SIDX_W-1:0] sync_idx;
  logic              ser_out_nxt, ser_valid_nxt, frame_done_nxt;
  logic              load, shift, shreg_msb;

  piso_shreg #(.W(DATA_W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (data_in),
    .msb   (shreg_msb)
  );

  // cnt holds the index of the bit currently on ser_out, so the next sync bit is cnt-1.
  assign sync_idx = SIDX_W'(cnt - CNT_W'(1));
  assign ready    = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ser_out    <= IDLE_BIT;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ser_out    <= ser_out_nxt;
      ser_valid  <= ser_valid_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ser_out_nxt    = IDLE_BIT;
    ser_valid_nxt  = 1'b0;
    frame_done_nxt = 1'b0;
    load           = 1'b0;
    shift          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load          = 1'b1;
          state_nxt     = S_SYNC;
          cnt_nxt       = CNT_W'(SYNC_W - 1);
          ser_out_nxt   = SYNC[SYNC_W-1];
          ser_valid_nxt = 1'b1;
        end
      end
      S_SYNC: begin
        ser_valid_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt      = S_DATA;
          cnt_nxt        = CNT_W'(DATA_W - 1);
          ser_out_nxt    = shreg_msb;
          shift          = 1'b1;
          frame_done_nxt = (DATA_W == 1);
        end else begin
          cnt_nxt     = cnt - CNT_W'(1);
          ser_out_nxt = SYNC[sync_idx];
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
          end
        end else begin
          ser_valid_nxt  = 1'b1;
          ser_out_nxt    = shreg_msb;
          shift          = 1'b1;
          cnt_nxt        = cnt - CNT_W'(1);
          frame_done_nxt = (cnt == CNT_W'(1));
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_111010_frame_tx.sv
// Scoreboard bench for seq_111010_frame_tx: stimulus queues expected bits, a monitor
// pops them whenever ser_valid is high and also runs a 111010 detector on the stream.
module tb_seq_111010_frame_tx;

  typedef struct packed {
    logic b;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, ser_out, ser_valid, frame_done;

  exp_t       exp_q[$];
  int         det_seen[$];
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  int         run_len = 0;
  int         det_len = 0;
  logic [5:0] det_hist = '0;
  exp_t       e;
  int         zeros;

  always #5 clk = ~clk;

  seq_111010_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .ready      (ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    start   = s;
    data_in = d;
  endtask

  // Expected line image of one frame: 111010 followed by the payload MSB first.
  task automatic pushFrame(input logic [7:0] d);
    logic [5:0] sw;
    sw = 6'b111010;
    for (int i = 5; i >= 0; i--) exp_q.push_back('{b: sw[i], done: 1'b0});
    for (int i = 7; i >= 0; i--) exp_q.push_back('{b: d[i], done: (i == 0)});
  endtask

  task automatic sendOne(input logic [7:0] d);
    @(posedge clk); #1;
    applyStimulus(1'b1, d);
    pushFrame(d);
    @(posedge clk); #1;
    applyStimulus(1'b0, d);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drain"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      run_len = 0;
      det_len = 0;
    end else begin
      det_hist = {det_hist[4:0], ser_out};
      if (det_len < 6) det_len++;
      if (ser_valid === 1'b1) begin
        run_len++;
        checkOutput("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("ser_out", ser_out, e.b);
          checkOutput("frame_done", frame_done, e.done);
        end
      end else begin
        checkOutput("idle_frame_done", frame_done, 0);
        checkOutput("idle_ser_out", ser_out, 0);
        if (run_len != 0) begin
          checkOutput("valid_run_len", run_len, 14);
          run_len = 0;
        end
      end
      if (det_len == 6 && det_hist == 6'b111010) begin
        det_seen.push_back((ser_valid === 1'b1) ? run_len : -1);
        det_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_ser_valid", ser_valid, 0);
    checkOutput("rst_ser_out", ser_out, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Single A5 frame with ready timing
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'hA5);
    pushFrame(8'hA5);
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1)  checkOutput("ready_c1", ready, 0);
      if (k == 16) checkOutput("ready_c16", ready, 0);
      if (k == 17) checkOutput("ready_c17", ready, 1);
    end
    waitDrain("a5");

    // Loopback detection: sync only
    det_seen.delete();
    sendOne(8'h00);
    waitDrain("p00");
    checkOutput("det00_count", det_seen.size(), 1);
    if (det_seen.size() >= 1) checkOutput("det00_pos", det_seen[0], 6);

    // Loopback detection: payload that contains the sync word
    det_seen.delete();
    sendOne(8'hE8);
    waitDrain("pE8");
    checkOutput("detE8_count", det_seen.size(), 2);
    if (det_seen.size() >= 2) begin
      checkOutput("detE8_pos0", det_seen[0], 6);
      checkOutput("detE8_pos1", det_seen[1], 12);
    end

    // Back-to-back frames with start held high
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'h3C);
    pushFrame(8'h3C);
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'hC3);
    pushFrame(8'hC3);
    zeros = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k >= 15 && k <= 17 && ser_valid === 1'b0) zeros++;
      if (k == 17) checkOutput("b2b_ready_c17", ready, 1);
      if (k == 18) checkOutput("b2b_valid_c18", ser_valid, 1);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("b2b_gap_zeros", zeros, 3);
    waitDrain("b2b");

    // start pulses and data_in changes mid-frame are ignored
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'h96);
    pushFrame(8'h96);
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h96);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3)  applyStimulus(1'b1, 8'hFF);
      if (k == 4)  applyStimulus(1'b0, 8'h5A);
      if (k == 10) applyStimulus(1'b1, 8'h00);
      if (k == 11) applyStimulus(1'b0, 8'h33);
    end
    waitDrain("ignore");
    repeat (10) @(negedge clk);
    checkOutput("ignore_ready", ready, 1);

    // Reset asserted in cycle 9 aborts the frame
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'h5A);
    pushFrame(8'h5A);
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h5A);
    for (int k = 1; k <= 9; k++) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("abort_ser_valid", ser_valid, 0);
    checkOutput("abort_ser_out", ser_out, 0);
    checkOutput("abort_frame_done", frame_done, 0);
    checkOutput("abort_ready", ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    sendOne(8'hFF);
    waitDrain("pFF");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
